// File: rtl/apv_event_arbiter_if.sv
// Output word stream from the APV event arbiter toward the formatter.
// Ports: DOUT (32b word), DOUT_VALID, DOUT_READY (valid/ready handshake).
interface apv_event_arbiter_if;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY;

    modport master (
        output DOUT,
        output DOUT_VALID,
        input  DOUT_READY
    );

    modport slave (
        input  DOUT,
        input  DOUT_VALID,
        output DOUT_READY
    );
endinterface

// File: rtl/apv_event_arbiter.sv
// APV event builder: drains masked channel FIFOs in ascending order and
// wraps the data with header/trailer words onto one 32-bit stream.
// Ports: CLK, RSTb (async low), ENABLE, CH_MASK, SAMPLE_PER_EVENT,
//   CH_EMPTY/CH_DATA/CH_RD (FIFO side), dout_if (master stream),
//   BUSY, EVENT_CNT, TIMEOUT_ERR, CLR_ERR.
// Optional: define APV_ARB_TIMEOUT_EN for the per-channel empty timeout.
module apv_event_arbiter #(
    parameter int NCH             = 8,
    parameter int WORDS_PER_FRAME = 65,
    parameter int TIMEOUT_CYC     = 4096
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic                ENABLE,
    input  logic [NCH-1:0]      CH_MASK,
    input  logic [4:0]          SAMPLE_PER_EVENT,
    input  logic [NCH-1:0]      CH_EMPTY,
    input  logic [26*NCH-1:0]   CH_DATA,
    output logic [NCH-1:0]      CH_RD,
    apv_event_arbiter_if.master dout_if,
    output logic                BUSY,
    output logic [15:0]         EVENT_CNT,
    output logic [NCH-1:0]      TIMEOUT_ERR,
    input  logic                CLR_ERR
);

    typedef enum logic [2:0] {
        IDLE, HDR, READ, NEXT, TRL, DRAIN
    } state_t;

    state_t         state;
    logic [NCH-1:0] mask_q;
    logic [15:0]    target;
    logic [15:0]    rd_cnt;
    logic [3:0]     ch_sel;
    logic [23:0]    word_cnt;

    // One read may be in flight; its data lands the following cycle.
    logic           pend;
    logic [3:0]     pend_ch;

    logic [31:0]    q_mem [4];
    logic [1:0]     wr_ptr;
    logic [1:0]     rd_ptr;
    logic [2:0]     q_cnt;

    logic           sel_empty;
    logic [25:0]    land_data;
    logic [3:0]     first_ch;
    logic [3:0]     next_ch;
    logic           next_ok;
    logic           issue;
    logic           hdr_push;
    logic           trl_push;
    logic           push;
    logic           pop;
    logic [31:0]    push_word;
    logic [4:0]     frames;
    logic           tmo_hit;

    always_comb begin
        sel_empty = 1'b1;
        land_data = '0;
        first_ch  = '0;
        next_ch   = '0;
        next_ok   = 1'b0;
        // Descending scan so the lowest qualifying index wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) first_ch = 4'(i);
            if (mask_q[i] && 4'(i) > ch_sel) begin
                next_ch = 4'(i);
                next_ok = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == 4'(i)) sel_empty = CH_EMPTY[i];
            if (pend_ch == 4'(i)) land_data = CH_DATA[26*i +: 26];
        end
    end

    // Count in-flight reads against queue room so nothing can be dropped.
    assign issue = (state == READ) && !sel_empty
                && ((q_cnt + {2'b00, pend}) < 3'd4);

    always_comb begin
        CH_RD = '0;
        for (int i = 0; i < NCH; i++)
            CH_RD[i] = issue && (ch_sel == 4'(i));
    end

    assign hdr_push = (state == HDR) && ((q_cnt + {2'b00, pend}) < 3'd4);
    assign trl_push = (state == TRL) && !pend && (q_cnt < 3'd4);
    assign push     = pend | hdr_push | trl_push;
    assign pop      = dout_if.DOUT_VALID && dout_if.DOUT_READY;
    assign frames   = (SAMPLE_PER_EVENT == 5'd0) ? 5'd1 : SAMPLE_PER_EVENT;

    always_comb begin
        push_word = {2'b11, 6'b0, word_cnt};
        unique case (1'b1)
            pend:     push_word = {2'b00, pend_ch, land_data};
            hdr_push: push_word = {2'b10, 14'b0, EVENT_CNT};
            default:  push_word = {2'b11, 6'b0, word_cnt};
        endcase
    end

    assign dout_if.DOUT       = q_mem[rd_ptr];
    assign dout_if.DOUT_VALID = (q_cnt != 3'd0);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            q_mem   <= '{default: '0};
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_cnt   <= '0;
            pend    <= 1'b0;
            pend_ch <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= push_word;
                wr_ptr        <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            q_cnt   <= q_cnt + 3'(push) - 3'(pop);
            pend    <= issue;
            pend_ch <= ch_sel;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state     <= IDLE;
            mask_q    <= '0;
            target    <= '0;
            rd_cnt    <= '0;
            ch_sel    <= '0;
            word_cnt  <= '0;
            BUSY      <= 1'b0;
            EVENT_CNT <= '0;
        end else begin
            unique case (state)
                IDLE: if (ENABLE && |CH_MASK) begin
                    mask_q   <= CH_MASK;
                    target   <= 16'(frames) * 16'(WORDS_PER_FRAME);
                    word_cnt <= '0;
                    BUSY     <= 1'b1;
                    state    <= HDR;
                end
                HDR: if (hdr_push) begin
                    ch_sel <= first_ch;
                    rd_cnt <= '0;
                    state  <= READ;
                end
                READ: if (issue) begin
                    rd_cnt   <= rd_cnt + 16'd1;
                    word_cnt <= word_cnt + 24'd1;
                    if (rd_cnt + 16'd1 == target) state <= NEXT;
                end else if (tmo_hit) begin
                    state <= NEXT;
                end
                NEXT: if (next_ok) begin
                    ch_sel <= next_ch;
                    rd_cnt <= '0;
                    state  <= READ;
                end else begin
                    state <= TRL;
                end
                TRL: if (trl_push) state <= DRAIN;
                DRAIN: if (q_cnt == 3'd0) begin
                    EVENT_CNT <= EVENT_CNT + 16'd1;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APV_ARB_TIMEOUT_EN
    logic [15:0]    tmo_cnt;
    logic [NCH-1:0] err_set;

    assign tmo_hit = (state == READ) && sel_empty
                  && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        err_set = '0;
        for (int i = 0; i < NCH; i++)
            err_set[i] = tmo_hit && (ch_sel == 4'(i));
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            tmo_cnt     <= '0;
            TIMEOUT_ERR <= '0;
        end else begin
            if (state != READ || issue || tmo_hit)
                tmo_cnt <= '0;
            else if (sel_empty)
                tmo_cnt <= tmo_cnt + 16'd1;
            // A fresh timeout overrides a simultaneous clear.
            TIMEOUT_ERR <= (CLR_ERR ? '0 : TIMEOUT_ERR) | err_set;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign TIMEOUT_ERR = '0;

    wire [16:0] unused_tmo = {CLR_ERR, 16'(TIMEOUT_CYC)};
`endif

endmodule

// File: tb/tb_apv_event_arbiter.sv
// Randomized bench for apv_event_arbiter with FIFO and stream models.
// Expected streams are built from the event rules, not from the RTL.
module tb_apv_event_arbiter;

    localparam int NCH = 4;
    localparam int WPF = 65;

    logic              CLK = 1'b0;
    logic              RSTb = 1'b0;
    logic              ENABLE = 1'b0;
    logic              CLR_ERR = 1'b0;
    logic [NCH-1:0]    CH_MASK = '0;
    logic [NCH-1:0]    CH_EMPTY = '1;
    logic [NCH-1:0]    CH_RD;
    logic [NCH-1:0]    TIMEOUT_ERR;
    logic [4:0]        SAMPLE_PER_EVENT = '0;
    logic [26*NCH-1:0] CH_DATA = '0;
    logic              BUSY;
    logic [15:0]       EVENT_CNT;

    apv_event_arbiter_if dout_if ();

    apv_event_arbiter #(
        .NCH             (NCH),
        .WORDS_PER_FRAME (WPF),
        .TIMEOUT_CYC     (100)
    ) dut (
        .CLK              (CLK),
        .RSTb             (RSTb),
        .ENABLE           (ENABLE),
        .CH_MASK          (CH_MASK),
        .SAMPLE_PER_EVENT (SAMPLE_PER_EVENT),
        .CH_EMPTY         (CH_EMPTY),
        .CH_DATA          (CH_DATA),
        .CH_RD            (CH_RD),
        .dout_if          (dout_if.master),
        .BUSY             (BUSY),
        .EVENT_CNT        (EVENT_CNT),
        .TIMEOUT_ERR      (TIMEOUT_ERR),
        .CLR_ERR          (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    logic [25:0]    fq [NCH][$];
    logic [25:0]    gen [NCH][$];
    logic [31:0]    got [$];
    logic [31:0]    exp_q [$];
    logic [NCH-1:0] pend_rd = '0;
    logic [NCH-1:0] hold = '0;
    int             popped [NCH];
    int             rdy_pct = 100;
    int             n_chk = 0;
    int             n_fail = 0;
    int             ev_model = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // FIFO + sink model. Reads taken at a posedge land before the next one.
    always begin
        @(negedge CLK);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (pend_rd[i] && fq[i].size() > 0) begin
                CH_DATA[26*i +: 26] = fq[i].pop_front();
                popped[i]++;
            end
        end
        dout_if.DOUT_READY = (int'($urandom_range(99)) < rdy_pct);
        for (int i = 0; i < NCH; i++)
            CH_EMPTY[i] = (fq[i].size() == 0) || hold[i];
        #1;
        pend_rd = CH_RD;
        if (CH_RD != '0)
            check("rd_while_empty", 32'(CH_RD & CH_EMPTY), 32'd0);
        if (dout_if.DOUT_VALID && dout_if.DOUT_READY)
            got.push_back(dout_if.DOUT);
    end

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(logic [NCH-1:0] m, int n);
        logic [31:0] w;
        for (int i = 0; i < NCH; i++) begin
            fq[i].delete();
            gen[i].delete();
            popped[i] = 0;
            if (m[i]) begin
                for (int k = 0; k < n; k++) begin
                    w = $urandom;
                    fq[i].push_back(w[25:0]);
                    gen[i].push_back(w[25:0]);
                end
            end
        end
        got.delete();
    endtask

    task automatic build_exp(logic [NCH-1:0] m, input int cnt[NCH]);
        int tot;
        tot = 0;
        exp_q.delete();
        exp_q.push_back({2'b10, 14'b0, 16'(ev_model)});
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < cnt[ch]; k++) begin
                    exp_q.push_back({2'b00, 4'(ch), gen[ch][k]});
                    tot++;
                end
            end
        end
        exp_q.push_back({2'b11, 6'b0, 24'(tot)});
    endtask

    task automatic compare_stream(string tag);
        int n;
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            check($sformatf("%s_w%0d", tag, k), got[k], exp_q[k]);
    endtask

    task automatic start_ev(logic [NCH-1:0] m, logic [4:0] spe, string tag);
        bit ok;
        ok = 1'b0;
        CH_MASK = m;
        SAMPLE_PER_EVENT = spe;
        ENABLE = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick(1);
            ok = BUSY;
        end
        ENABLE = 1'b0;
        check({tag, "_start"}, 32'(ok), 32'd1);
        // Mid-event changes must not affect the running event.
        CH_MASK = ~m;
        SAMPLE_PER_EVENT = 5'd7;
    endtask

    task automatic wait_done(string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20000 && !ok; c++) begin
            tick(1);
            ok = !BUSY;
        end
        check({tag, "_done"}, 32'(ok), 32'd1);
        tick(5);
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic run_event(logic [NCH-1:0] m, logic [4:0] spe,
                             int pct, string tag);
        int n;
        int cnt [NCH];
        n = (spe == 5'd0) ? WPF : int'(spe) * WPF;
        load(m, n);
        rdy_pct = pct;
        start_ev(m, spe, tag);
        wait_done(tag);
        for (int i = 0; i < NCH; i++) cnt[i] = m[i] ? n : 0;
        build_exp(m, cnt);
        compare_stream(tag);
        ev_model++;
        check({tag, "_evcnt"}, 32'(EVENT_CNT), 32'(ev_model));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [NCH];
        bit ok;

        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_valid", 32'(dout_if.DOUT_VALID), 32'd0);
        check("rst_dout", dout_if.DOUT, 32'd0);
        check("rst_evcnt", 32'(EVENT_CNT), 32'd0);
        check("rst_rd", 32'(CH_RD), 32'd0);
        tick(2);
        RSTb = 1'b1;
        tick(2);

        // Empty mask never starts an event.
        CH_MASK = '0;
        ENABLE = 1'b1;
        tick(10);
        check("mask0_busy", 32'(BUSY), 32'd0);
        ENABLE = 1'b0;

        run_event(4'b0101, 5'd1, 100, "t1");
        if (got.size() > 0)
            check("t1_hdr", got[0], 32'h8000_0000);
        if (got.size() > 0)
            check("t1_trl", got[got.size()-1], 32'hC000_0082);

        run_event(4'b0001, 5'd3, 100, "t2");
        if (got.size() > 0)
            check("t2_trl", got[got.size()-1], 32'hC000_00C3);
        run_event(4'b0001, 5'd0, 100, "t3");
        run_event(4'b0001, 5'd0, 30, "t4");
        run_event(4'b1110, 5'd2, 50, "t5");

        // Channel 1 goes empty mid-frame for 200 cycles.
        load(4'b0011, WPF);
        rdy_pct = 100;
        start_ev(4'b0011, 5'd1, "stall");
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            tick(1);
            ok = (fq[1].size() <= 30);
        end
        check("stall_reach", 32'(ok), 32'd1);
        hold[1] = 1'b1;
        tick(200);
`ifdef APV_ARB_TIMEOUT_EN
        check("tmo_flag", 32'(TIMEOUT_ERR[1]), 32'd1);
        hold[1] = 1'b0;
        wait_done("stall");
        cnt = '{WPF, popped[1], 0, 0};
        build_exp(4'b0011, cnt);
        compare_stream("stall");
        ev_model++;
        CLR_ERR = 1'b1;
        tick(1);
        CLR_ERR = 1'b0;
        check("tmo_clr", 32'(TIMEOUT_ERR), 32'd0);
`else
        check("stall_busy", 32'(BUSY), 32'd1);
        check("stall_err", 32'(TIMEOUT_ERR), 32'd0);
        hold[1] = 1'b0;
        wait_done("stall");
        cnt = '{WPF, WPF, 0, 0};
        build_exp(4'b0011, cnt);
        compare_stream("stall");
        ev_model++;
`endif
        check("stall_evcnt", 32'(EVENT_CNT), 32'(ev_model));

        // Asynchronous reset in the middle of an event.
        load(4'b0001, WPF);
        rdy_pct = 100;
        start_ev(4'b0001, 5'd1, "mid");
        tick(30);
        RSTb = 1'b0;
        #1;
        check("mrst_busy", 32'(BUSY), 32'd0);
        check("mrst_valid", 32'(dout_if.DOUT_VALID), 32'd0);
        check("mrst_dout", dout_if.DOUT, 32'd0);
        check("mrst_evcnt", 32'(EVENT_CNT), 32'd0);
        check("mrst_rd", 32'(CH_RD), 32'd0);
        check("mrst_err", 32'(TIMEOUT_ERR), 32'd0);
        tick(2);
        RSTb = 1'b1;
        ev_model = 0;
        tick(2);

        run_event(4'b1000, 5'd2, 60, "post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
